// File: rtl/group_arbiter_if.sv
// Bus bundle between the group scheduler and the pixel groups / event consumer.
// Event handshake: the head entry transfers on a rising clk_i edge where evt_valid_o & evt_ready_i; evt_* stay stable while valid & !ready.
interface group_arbiter_if #(
  parameter int NUM_GRPS = 4,
  parameter int GRP_W    = 2,
  parameter int PIX_W    = 2,
  parameter int TS_W     = 16
);
  logic [NUM_GRPS-1:0]       grp_req_i;
  logic [NUM_GRPS-1:0]       grp_active_i;
  logic [NUM_GRPS-1:0]       grp_release_i;
  logic [NUM_GRPS*PIX_W-1:0] grp_x_add_i;
  logic [NUM_GRPS*PIX_W-1:0] grp_y_add_i;
  logic [NUM_GRPS-1:0]       grp_enable_o;
  logic                      evt_valid_o;
  logic                      evt_ready_i;
  logic [GRP_W-1:0]          evt_grp_o;
  logic [PIX_W-1:0]          evt_x_o;
  logic [PIX_W-1:0]          evt_y_o;
  logic [TS_W-1:0]           evt_ts_o;
  logic                      busy_o;
  logic                      overflow_o;
  logic [1:0]                state_o;

  modport slave (
    input  grp_req_i, grp_active_i, grp_release_i, grp_x_add_i, grp_y_add_i, evt_ready_i,
    output grp_enable_o, evt_valid_o, evt_grp_o, evt_x_o, evt_y_o, evt_ts_o,
           busy_o, overflow_o, state_o
  );

  modport master (
    output grp_req_i, grp_active_i, grp_release_i, grp_x_add_i, grp_y_add_i, evt_ready_i,
    input  grp_enable_o, evt_valid_o, evt_grp_o, evt_x_o, evt_y_o, evt_ts_o,
           busy_o, overflow_o, state_o
  );
endinterface

// File: rtl/group_arbiter.sv
// Round-robin scheduler sharing one event bus among pixel groups; events are
// timestamped and queued in a small FIFO ahead of a valid/ready output.
module group_arbiter #(
  parameter int NUM_GRPS   = 4,
  parameter int GRP_W      = 2,
  parameter int PIX_W      = 2,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_HOLD   = 32
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  group_arbiter_if.slave    bus
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [GRP_W-1:0] grp;
    logic [PIX_W-1:0] x;
    logic [PIX_W-1:0] y;
    logic [TS_W-1:0]  ts;
  } evt_t;

  state_e              state_q, state_d;
  logic [GRP_W-1:0]    sel_q, sel_d;
  logic [GRP_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                drain_q, drain_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_q, wr_d;
  logic [PTR_W-1:0]    rd_q, rd_d;
  logic                ovf_q, ovf_d;
  evt_t                mem_q [FIFO_DEPTH];
  evt_t                mem_d [FIFO_DEPTH];

  logic                found;
  logic [GRP_W-1:0]    pick;
  logic [GRP_W-1:0]    cand;
  logic                room_ok;
  logic                full;
  logic                capture;
  logic                push;
  logic                pop;
  logic [NUM_GRPS-1:0] enable;
  evt_t                entry;
  evt_t                head;

  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    for (int i = 1; i <= NUM_GRPS; i++) begin
      cand = GRP_W'((int'(ptr_q) + i) % NUM_GRPS);
      if (!found && bus.grp_req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    drain_d = drain_q;
    ts_d    = ts_q + 1'b1;
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    mem_d   = mem_q;
    enable  = '0;

    full    = (count_q == CNT_W'(FIFO_DEPTH));
    // Two free slots absorb events already in flight behind a dropped enable.
    room_ok = (count_q <= CNT_W'(FIFO_DEPTH - 3));

    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (room_ok) enable[sel_q] = 1'b1;
        hold_d = hold_q + 1'b1;
        if (bus.grp_release_i[sel_q] || !bus.grp_req_i[sel_q] ||
            hold_q == HOLD_W'(MAX_HOLD - 1)) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = IDLE;
          ptr_d   = sel_q;
        end
      end
      default: state_d = IDLE;
    endcase

    entry.grp = sel_q;
    entry.x   = bus.grp_x_add_i[sel_q*PIX_W +: PIX_W];
    entry.y   = bus.grp_y_add_i[sel_q*PIX_W +: PIX_W];
    entry.ts  = ts_q;

    capture = (state_q != IDLE) && bus.grp_active_i[sel_q];
    pop     = (count_q != '0) && bus.evt_ready_i;
    // When full, a simultaneous pop frees the slot being written.
    push    = capture && (!full || pop);
    if (capture && full && !pop) ovf_d = 1'b1;

    if (push) begin
      mem_d[wr_q] = entry;
      wr_d = (wr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = (rd_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
    end
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= GRP_W'(NUM_GRPS - 1);
      hold_q  <= '0;
      drain_q <= 1'b0;
      ts_q    <= '0;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      drain_q <= drain_d;
      ts_q    <= ts_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
    end
  end

  assign head             = (count_q != '0) ? mem_q[rd_q] : '0;
  assign bus.grp_enable_o = enable;
  assign bus.evt_valid_o  = (count_q != '0);
  assign bus.evt_grp_o    = head.grp;
  assign bus.evt_x_o      = head.x;
  assign bus.evt_y_o      = head.y;
  assign bus.evt_ts_o     = head.ts;
  assign bus.busy_o       = (state_q != IDLE) || (count_q != '0);
  assign bus.overflow_o   = ovf_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_group_arbiter.sv
// Randomized bench for group_arbiter: a cycle-level behavioural model predicts
// enables and status, and a scoreboard queue predicts the delivered events.
module tb_group_arbiter;
  localparam int NUM_GRPS   = 4;
  localparam int GRP_W      = 2;
  localparam int PIX_W      = 2;
  localparam int TS_W       = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_HOLD   = 32;
  localparam int EVT_W      = GRP_W + 2*PIX_W + TS_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  group_arbiter_if #(.NUM_GRPS(NUM_GRPS), .GRP_W(GRP_W), .PIX_W(PIX_W), .TS_W(TS_W)) bus();

  group_arbiter #(
    .NUM_GRPS(NUM_GRPS), .GRP_W(GRP_W), .PIX_W(PIX_W), .TS_W(TS_W),
    .FIFO_DEPTH(FIFO_DEPTH), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk_i   (clk),
    .reset_ni(rst_n),
    .bus     (bus)
  );

  // ---------------- scoreboard / model state ----------------
  int total = 0;
  int bad   = 0;
  logic [EVT_W-1:0] exp_q[$];

  int          m_sel;      // group being served, -1 while arbitrating
  int          m_last;     // last group that finished service
  int          m_served;   // enabled cycles spent by m_sel so far
  int          m_drain;    // remaining post-service cycles
  int          m_cnt;      // events held in the output buffer
  int unsigned m_ts;
  bit          m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel    = -1;
    m_last   = NUM_GRPS - 1;
    m_served = 0;
    m_drain  = 0;
    m_cnt    = 0;
    m_ts     = 0;
    m_ovf    = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [NUM_GRPS-1:0] rbits(input int pct);
    logic [NUM_GRPS-1:0] b;
    for (int i = 0; i < NUM_GRPS; i++) b[i] = ($urandom_range(99) < pct);
    return b;
  endfunction

  task automatic drive_idle();
    bus.grp_req_i     = '0;
    bus.grp_active_i  = '0;
    bus.grp_release_i = '0;
    bus.grp_x_add_i   = '0;
    bus.grp_y_add_i   = '0;
    bus.evt_ready_i   = 1'b0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called at a falling edge: checks this cycle's outputs, drives inputs,
  // advances the model across the next rising edge, then waits a cycle.
  task automatic cycle(input logic [NUM_GRPS-1:0] req_mask, input int p_req,
                       input int p_rel, input int p_act, input int p_rdy);
    logic [NUM_GRPS-1:0]       exp_en, req, rel, act;
    logic [NUM_GRPS*PIX_W-1:0] xv, yv;
    logic                      rdy, cap, pop;
    int                        w;

    exp_en = '0;
    if (m_sel >= 0 && m_drain == 0 && (FIFO_DEPTH - m_cnt) >= 3) exp_en[m_sel] = 1'b1;
    check("enable",   32'(bus.grp_enable_o), 32'(exp_en));
    check("valid",    32'(bus.evt_valid_o),  32'(m_cnt != 0));
    check("busy",     32'(bus.busy_o),       32'(m_sel >= 0 || m_cnt != 0));
    check("overflow", 32'(bus.overflow_o),   32'(m_ovf));

    req = rbits(p_req) & req_mask;
    rel = rbits(p_rel);
    act = rbits(p_act);
    xv  = NUM_GRPS*PIX_W'($urandom);
    yv  = NUM_GRPS*PIX_W'($urandom);
    rdy = ($urandom_range(99) < p_rdy);
    bus.grp_req_i     = req;
    bus.grp_release_i = rel;
    bus.grp_active_i  = act;
    bus.grp_x_add_i   = xv;
    bus.grp_y_add_i   = yv;
    bus.evt_ready_i   = rdy;

    cap = (m_sel >= 0) && act[m_sel];
    pop = (m_cnt > 0) && rdy;
    if (cap && (m_cnt < FIFO_DEPTH || pop)) begin
      exp_q.push_back({GRP_W'(m_sel), xv[m_sel*PIX_W +: PIX_W], yv[m_sel*PIX_W +: PIX_W], TS_W'(m_ts)});
      m_cnt++;
    end else if (cap) begin
      m_ovf = 1'b1;
    end
    if (pop) m_cnt--;
    m_ts = (m_ts + 1) % (1 << TS_W);

    if (m_sel < 0) begin
      w = -1;
      for (int i = 1; i <= NUM_GRPS; i++)
        if (w < 0 && req[(m_last + i) % NUM_GRPS]) w = (m_last + i) % NUM_GRPS;
      if (w >= 0) begin
        m_sel    = w;
        m_served = 0;
      end
    end else if (m_drain == 0) begin
      m_served++;
      if (rel[m_sel] || !req[m_sel] || m_served == MAX_HOLD) m_drain = 2;
    end else begin
      m_drain--;
      if (m_drain == 0) begin
        m_last = m_sel;
        m_sel  = -1;
      end
    end

    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_enable",   32'(bus.grp_enable_o), 32'h0);
    check("rst_valid",    32'(bus.evt_valid_o),  32'h0);
    check("rst_busy",     32'(bus.busy_o),       32'h0);
    check("rst_overflow", 32'(bus.overflow_o),   32'h0);
    check("rst_evt",      32'({bus.evt_grp_o, bus.evt_x_o, bus.evt_y_o, bus.evt_ts_o}), 32'h0);
    check("rst_state",    32'(bus.state_o),      32'h0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EVT_W-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.evt_valid_o && bus.evt_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL evt_unexpected: got %0h expected no event at %0t",
                   {bus.evt_grp_o, bus.evt_x_o, bus.evt_y_o, bus.evt_ts_o}, $time);
        end else begin
          e = exp_q.pop_front();
          check("evt_data", 32'({bus.evt_grp_o, bus.evt_x_o, bus.evt_y_o, bus.evt_ts_o}), 32'(e));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    model_reset();
    #1;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Every group requesting: round-robin order and enable gaps.
    for (int i = 0; i < 150; i++) cycle(4'b1111, 100, 25, 40, 100);
    // Only group 2, ready toggling.
    for (int i = 0; i < 100; i++) cycle(4'b0100, 100, 10, 50, 60);
    // Group 0 alone, never releasing: service bounded by the hold limit.
    for (int i = 0; i < 90; i++) cycle(4'b0001, 100, 0, 20, 100);
    // Group 0 never releasing while others request too.
    for (int i = 0; i < 90; i++) cycle(4'b1111, 100, 0, 30, 100);
    // Fully random traffic.
    for (int i = 0; i < 250; i++) cycle(4'b1111, 50, 20, 50, 70);
    // Group 1 streaming with no consumer: enable throttles, buffer fills.
    for (int i = 0; i < 20; i++) cycle(4'b0010, 100, 0, 100, 0);
    // Random traffic with no consumer: drops and sticky overflow.
    for (int i = 0; i < 60; i++) cycle(4'b1111, 80, 10, 70, 0);
    // Consumer returns; buffered events drain in order, overflow stays set.
    for (int i = 0; i < 60; i++) cycle(4'b1111, 80, 20, 40, 100);

    // Asynchronous reset in the middle of a cycle with traffic in flight.
    for (int i = 0; i < 6; i++) cycle(4'b1111, 100, 0, 80, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 120; i++) cycle(4'b1111, 100, 25, 50, 80);
    // Let everything drain.
    for (int i = 0; i < 20; i++) cycle(4'b0000, 0, 0, 0, 100);
    check("leftover_events", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
